// File: rtl/melody_sequencer.sv
// Melody sequencer: plays a fixed 16-entry note ROM as a square-wave tone with loop/stop control.
// Optional feature: define MELODY_GAP_EN to insert GAP_TICKS silent ticks after every note.
module melody_sequencer #(
    parameter logic [27:0] TICK_DIV  = 28'd5000000,
    parameter logic [3:0]  GAP_TICKS = 4'd1
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic       clock_out,
    output logic [2:0] note_idx,
    output logic [3:0] step,
    output logic       busy,
    output logic       done
);

`ifdef MELODY_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1} state_t;
`endif

    function automatic logic [27:0] note_div(input logic [2:0] n);
        logic [27:0] d;
        case (n)
            3'd0:    d = 28'd191205;
            3'd1:    d = 28'd170265;
            3'd2:    d = 28'd151685;
            3'd3:    d = 28'd143172;
            3'd4:    d = 28'd127551;
            3'd5:    d = 28'd113636;
            3'd6:    d = 28'd101239;
            3'd7:    d = 28'd95602;
            default: d = 28'd191205;
        endcase
        return d;
    endfunction

    // Entry layout {rest, note[2:0], dur[3:0]}; a zero duration marks the end of the melody.
    function automatic logic [7:0] melody_rom(input logic [3:0] s);
        logic [7:0] e;
        case (s)
            4'd0:    e = 8'h02;
            4'd1:    e = 8'h12;
            4'd2:    e = 8'h22;
            4'd3:    e = 8'h32;
            4'd4:    e = 8'h42;
            4'd5:    e = 8'h52;
            4'd6:    e = 8'h62;
            4'd7:    e = 8'h72;
            4'd8:    e = 8'h84;
            default: e = 8'h80;
        endcase
        return e;
    endfunction

    state_t      state_r, state_nx_s;
    logic [3:0]  step_r, step_nx_s;
    logic [27:0] tick_r, tick_nx_s;
    logic [3:0]  tcnt_r, tcnt_nx_s;
    logic [27:0] tone_r, tone_nx_s;

    logic        clock_out_r, busy_r, done_r;
    logic [2:0]  note_idx_r;
    logic        clock_out_nx_s, busy_nx_s, done_nx_s;
    logic [2:0]  note_idx_nx_s;

    logic [7:0]  entry_s, entry_nx_s;
    logic [3:0]  dur_s;
    logic [27:0] div_s, div_nx_s;
    logic        tick_last_s, note_end_s;

    assign entry_s     = melody_rom(step_r);
    assign dur_s       = entry_s[3:0];
    assign div_s       = note_div(entry_s[6:4]);
    assign tick_last_s = (tick_r == (TICK_DIV - 28'd1));
    assign note_end_s  = tick_last_s && (({1'b0, tcnt_r} + 5'd1) >= {1'b0, dur_s});

`ifdef MELODY_GAP_EN
    logic gap_end_s;
    assign gap_end_s = tick_last_s && (({1'b0, tcnt_r} + 5'd1) >= {1'b0, GAP_TICKS});
`else
    logic [3:0] gap_cfg_unused_s;
    assign gap_cfg_unused_s = GAP_TICKS;
`endif

    // State register and registered outputs.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_r     <= IDLE;
            step_r      <= 4'd0;
            tick_r      <= 28'd0;
            tcnt_r      <= 4'd0;
            tone_r      <= 28'd0;
            clock_out_r <= 1'b0;
            note_idx_r  <= 3'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            step_r      <= step_nx_s;
            tick_r      <= tick_nx_s;
            tcnt_r      <= tcnt_nx_s;
            tone_r      <= tone_nx_s;
            clock_out_r <= clock_out_nx_s;
            note_idx_r  <= note_idx_nx_s;
            busy_r      <= busy_nx_s;
            done_r      <= done_nx_s;
        end
    end

    // Next-state logic; counters clear by default so every entry to PLAY/GAP starts from zero.
    always_comb begin
        state_nx_s = state_r;
        step_nx_s  = step_r;
        tick_nx_s  = 28'd0;
        tcnt_nx_s  = 4'd0;
        tone_nx_s  = 28'd0;
        if (stop) begin
            state_nx_s = IDLE;
            step_nx_s  = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    step_nx_s = 4'd0;
                    if (start) begin
                        state_nx_s = PLAY;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                PLAY: begin
                    if (dur_s == 4'd0) begin
                        state_nx_s = loop ? PLAY : IDLE;
                        step_nx_s  = 4'd0;
                    end else if (note_end_s) begin
`ifdef MELODY_GAP_EN
                        state_nx_s = GAP;
`else
                        step_nx_s  = step_r + 4'd1;
`endif
                    end else begin
                        tick_nx_s = tick_last_s ? 28'd0 : (tick_r + 28'd1);
                        tcnt_nx_s = tick_last_s ? (tcnt_r + 4'd1) : tcnt_r;
                        tone_nx_s = (tone_r >= (div_s - 28'd1)) ? 28'd0 : (tone_r + 28'd1);
                    end
                end
`ifdef MELODY_GAP_EN
                GAP: begin
                    if (gap_end_s) begin
                        state_nx_s = PLAY;
                        step_nx_s  = step_r + 4'd1;
                    end else begin
                        tick_nx_s = tick_last_s ? 28'd0 : (tick_r + 28'd1);
                        tcnt_nx_s = tick_last_s ? (tcnt_r + 4'd1) : tcnt_r;
                    end
                end
`endif
                default: begin
                    state_nx_s = IDLE;
                    step_nx_s  = 4'd0;
                end
            endcase
        end
    end

    assign entry_nx_s = melody_rom(step_nx_s);
    assign div_nx_s   = note_div(entry_nx_s[6:4]);

    // Output values for the coming cycle, derived from the next state so registering adds no latency.
    always_comb begin
        busy_nx_s      = (state_nx_s != IDLE);
        done_nx_s      = (state_nx_s == PLAY) && (entry_nx_s[3:0] == 4'd0);
        note_idx_nx_s  = entry_nx_s[6:4];
        clock_out_nx_s = (state_nx_s == PLAY) && !entry_nx_s[7] && (entry_nx_s[3:0] != 4'd0)
                         && (tone_nx_s < {1'b0, div_nx_s[27:1]});
    end

    assign clock_out = clock_out_r;
    assign note_idx  = note_idx_r;
    assign step      = step_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 28'd5000000, clock_in cycles per duration tick (100 ms at 50 MHz).
REQ-002 Parameter GAP_TICKS, default 4'd1, silent ticks inserted between notes when gaps are enabled.
REQ-003 clock_in  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level; when sampled high in IDLE, begins playback at step 0.
REQ-006 stop  input  1  level; aborts playback.
REQ-007 loop  input  1  when high at end of melody, playback restarts at step 0.
REQ-008 clock_out  output  1  square-wave tone for the current note; 0 when silent.
REQ-009 note_idx  output  3  note index of the current step (0=Do .. 7=Do').
REQ-010 step  output  4  current melody table index.
REQ-011 busy  output  1  high in PLAY and GAP.
REQ-012 done  output  1  one-cycle pulse at end of melody.

Function
REQ-013 The note table SHALL be a 28-bit divisor ROM: 191205, 170265, 151685, 143172, 127551, 113636, 101239, 95602 for indices 0..7.
REQ-014 The melody ROM SHALL have 16 entries of {rest[7], note[6:4], dur[3:0]}: entries 0..7 = note i, dur 2; entry 8 = rest, dur 4; entry 9 and all above = dur 0 (end marker).
REQ-015 The FSM SHALL have states IDLE, PLAY, GAP, with transitions IDLE->PLAY on start, PLAY->GAP/PLAY/IDLE at note end, GAP->PLAY at gap end.
REQ-016 The tick counter SHALL count 0..TICK_DIV-1, wrap, and clear on every entry to PLAY or GAP.
REQ-017 A note SHALL last exactly dur*TICK_DIV clock_in cycles, measured from the first PLAY cycle of that step.
REQ-018 The tone counter SHALL count 0..divisor-1 and wrap, and it SHALL clear on every step change.
REQ-019 clock_out SHALL equal (tone counter < divisor/2) in PLAY for a non-rest entry, and 0 in IDLE, GAP, and rest entries.
REQ-020 At note end, step SHALL increment; 15 wraps to 0.
REQ-021 On entering a step whose dur is 0, the block SHALL assert done for one cycle; that step occupies no play time.
REQ-022 At that done cycle, if loop is high the block SHALL go to PLAY at step 0; otherwise it SHALL go to IDLE with step 0.
REQ-023 stop high in any state SHALL force IDLE on the next cycle, with step 0, clock_out 0, and no done pulse.
REQ-024 start and stop high together SHALL resolve as stop (stop wins).
REQ-025 start while busy SHALL be ignored.
REQ-026 note_idx SHALL reflect the note field of the current melody entry at all times.

Reset
REQ-027 Reset SHALL force state IDLE and clear the tick and tone counters.
REQ-028 Reset SHALL drive step=0, note_idx=0, clock_out=0, busy=0, done=0.
REQ-029 Reset SHALL take priority over start and stop.
REQ-030 Reset asserted mid-note SHALL take effect on the next edge with no done pulse.

Configuration
REQ-031 The gap feature SHALL be controlled by the macro MELODY_GAP_EN.
REQ-032 With MELODY_GAP_EN defined, every note end SHALL pass through GAP for GAP_TICKS*TICK_DIV cycles with clock_out=0 before the next step plays; the end marker SHALL be evaluated after the gap.
REQ-033 Without MELODY_GAP_EN, the GAP state and its logic SHALL be absent and PLAY SHALL advance directly to the next step.

Verification (TICK_DIV=10, GAP_TICKS=1)
REQ-034 Reset, then start pulse -> next cycle busy=1, step=0, note_idx=0; clock_out toggles with period 191205 cycles; step=1 after exactly 20 cycles (gap off).
REQ-035 Full run, loop=0, gap off -> steps 0..8 occupy 16*10+40=200 cycles; done pulses once at step 9; then busy=0, step=0.
REQ-036 Full run, loop=1 -> done pulses and step=0 on the next cycle with busy held high; second pass timing identical to the first.
REQ-037 stop asserted at step 3, mid-note -> next cycle IDLE, clock_out=0, step=0, no done; start and stop high together in IDLE -> remains IDLE.
REQ-038 With MELODY_GAP_EN defined -> each note is followed by 10 cycles of clock_out=0 with busy=1; step 0->1 transition occurs at cycle 30.
REQ-039 reset asserted during step 8 (rest) -> all outputs return to reset values on the next edge; a later start replays from step 0.
